// File: rtl/i2s_tx_param.sv
// I2S/left-justified stereo transmitter with parameterised widths and clock dividers.
// Optional macro SPK_UNDERRUN_REPEAT_EN: an underrun repeats the last pair instead of zeros.
module i2s_tx_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_W    = 16,
    parameter int unsigned SCK_DIV   = 16,
    parameter int unsigned MCLK_DIV  = 4,
    parameter int unsigned I2S_DELAY = 0
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic              audio_sdin,
    output logic              frame_start,
    output logic              underrun
);
    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned MW      = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int unsigned CW      = $clog2(SCK_DIV);
    localparam int unsigned BW      = $clog2(FRAME_W);

    logic [MW-1:0]      r_mclk_cnt, w_mclk_cnt_d;
    logic [CW-1:0]      r_sck_cnt, w_sck_cnt_d;
    logic [BW-1:0]      r_bit_cnt, w_bit_cnt_d;
    logic [FRAME_W-1:0] r_sr, w_sr_d, w_frame;
    logic               r_dly, w_dly_d;
    logic [DATA_W-1:0]  r_hold_l, r_hold_r, w_load_l, w_load_r;
    logic               r_hold_full, w_hold_full_d;
    logic               r_ready, r_mclk, r_lrck, r_sck, r_sdin, r_frame_start, r_underrun;
    logic               w_sck_wrap, w_frame_end, w_boundary, w_accept, w_sdin_d;
`ifdef SPK_UNDERRUN_REPEAT_EN
    logic [DATA_W-1:0]  r_last_l, r_last_r;
`endif

    always_comb begin
        w_mclk_cnt_d = (r_mclk_cnt == MW'(MCLK_DIV - 1)) ? '0 : r_mclk_cnt + 1'b1;
        w_sck_wrap   = (r_sck_cnt == CW'(SCK_DIV - 1));
        w_sck_cnt_d  = w_sck_wrap ? '0 : r_sck_cnt + 1'b1;
        w_frame_end  = (r_bit_cnt == BW'(FRAME_W - 1));
        w_bit_cnt_d  = r_bit_cnt;
        if (w_sck_wrap) begin
            w_bit_cnt_d = w_frame_end ? '0 : r_bit_cnt + 1'b1;
        end
        w_boundary = w_sck_wrap & w_frame_end;
        w_accept   = s_valid & r_ready;

        w_load_l = r_hold_l;
        w_load_r = r_hold_r;
        if (!r_hold_full) begin
`ifdef SPK_UNDERRUN_REPEAT_EN
            w_load_l = r_last_l;
            w_load_r = r_last_r;
`else
            w_load_l = '0;
            w_load_r = '0;
`endif
        end
        // Each slot carries its sample MSB-first, padded with zeros below.
        w_frame = '0;
        w_frame[FRAME_W-1 -: DATA_W] = w_load_l;
        w_frame[SLOT_W-1 -: DATA_W]  = w_load_r;

        w_hold_full_d = w_boundary ? w_accept : (r_hold_full | w_accept);

        w_sr_d  = r_sr;
        w_dly_d = r_dly;
        if (w_sck_wrap) begin
            w_dly_d = r_sr[FRAME_W-1];
            w_sr_d  = w_boundary ? w_frame : {r_sr[FRAME_W-2:0], 1'b0};
        end
        w_sdin_d = (I2S_DELAY != 0) ? w_dly_d : w_sr_d[FRAME_W-1];
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_mclk_cnt    <= '0;
            r_sck_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_sr          <= '0;
            r_dly         <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_hold_full   <= 1'b0;
            r_ready       <= 1'b0;
            r_mclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_sck         <= 1'b0;
            r_sdin        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
`ifdef SPK_UNDERRUN_REPEAT_EN
            r_last_l      <= '0;
            r_last_r      <= '0;
`endif
        end else begin
            r_mclk_cnt    <= w_mclk_cnt_d;
            r_sck_cnt     <= w_sck_cnt_d;
            r_bit_cnt     <= w_bit_cnt_d;
            r_sr          <= w_sr_d;
            r_dly         <= w_dly_d;
            r_hold_full   <= w_hold_full_d;
            r_ready       <= ~w_hold_full_d;
            // Output levels are decoded from the next counter values so they stay registered.
            r_mclk        <= (w_mclk_cnt_d >= MW'(MCLK_DIV / 2));
            r_sck         <= (w_sck_cnt_d >= CW'(SCK_DIV / 2));
            r_lrck        <= (w_bit_cnt_d >= BW'(SLOT_W));
            r_sdin        <= w_sdin_d;
            r_frame_start <= w_boundary;
            r_underrun    <= w_boundary & ~r_hold_full;
            if (w_accept) begin
                r_hold_l <= s_left;
                r_hold_r <= s_right;
            end
`ifdef SPK_UNDERRUN_REPEAT_EN
            if (w_boundary) begin
                r_last_l <= w_load_l;
                r_last_r <= w_load_r;
            end
`endif
        end
    end

    assign s_ready     = r_ready;
    assign audio_mclk  = r_mclk;
    assign audio_lrck  = r_lrck;
    assign audio_sck   = r_sck;
    assign audio_sdin  = r_sdin;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_param.sv
// Randomised bench for i2s_tx_param against a cycle-time arithmetic model of frames and handshake.
// A second instance (DATA_W=12, I2S_DELAY=1) checks delayed, padded slots.
module tb_i2s_tx_param;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned SLOT_W    = 16;
    localparam int unsigned SCK_DIV   = 16;
    localparam int unsigned MCLK_DIV  = 4;
    localparam int unsigned I2S_DELAY = 0;
    localparam int unsigned FRAME_W   = 2 * SLOT_W;
    localparam int unsigned P         = SCK_DIV * FRAME_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_left, s_right;
    logic              s_valid;
    logic              s_ready, audio_mclk, audio_lrck, audio_sck, audio_sdin;
    logic              frame_start, underrun;
    logic [11:0]       b_left  = 12'hABC;
    logic [11:0]       b_right = 12'h123;
    logic              b_valid = 1'b1;
    logic              b_ready, b_mclk, b_lrck, b_sck, b_sdin, b_fs, b_uf;

    i2s_tx_param u_dut (
        .clk_100mhz(clk), .rst(rst), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
        .s_ready(s_ready), .audio_mclk(audio_mclk), .audio_lrck(audio_lrck),
        .audio_sck(audio_sck), .audio_sdin(audio_sdin), .frame_start(frame_start),
        .underrun(underrun)
    );

    i2s_tx_param #(.DATA_W(12), .SLOT_W(16), .SCK_DIV(16), .MCLK_DIV(4), .I2S_DELAY(1)) u_dut12 (
        .clk_100mhz(clk), .rst(rst), .s_left(b_left), .s_right(b_right), .s_valid(b_valid),
        .s_ready(b_ready), .audio_mclk(b_mclk), .audio_lrck(b_lrck), .audio_sck(b_sck),
        .audio_sdin(b_sdin), .frame_start(b_fs), .underrun(b_uf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: t counts non-reset clock edges since the last reset.
    int unsigned       t;
    bit                m_full, m_rdy_ok, m_fs, m_uf;
    logic [DATA_W-1:0] m_hold_l, m_hold_r, m_last_l, m_last_r;
    logic [FRAME_W-1:0] m_cur, m_prev;
    logic [31:0]       cap1, cap2;
    int                uf_seen;
    logic [15:0]       exp12_l = 16'h55E0;
    logic [15:0]       exp12_r = 16'h0918;

    function automatic logic [FRAME_W-1:0] frame_of(input logic [DATA_W-1:0] l,
                                                    input logic [DATA_W-1:0] r);
        return (FRAME_W'(l) << (FRAME_W - DATA_W)) | (FRAME_W'(r) << (SLOT_W - DATA_W));
    endfunction

    task automatic check_outputs();
        int unsigned b;
        int unsigned sb;
        logic        exp_sdin;
        b = (t / SCK_DIV) % FRAME_W;
        if (I2S_DELAY == 0) exp_sdin = m_cur[FRAME_W-1-b];
        else                exp_sdin = (b == 0) ? m_prev[0] : m_cur[FRAME_W-b];
        check("mclk", audio_mclk, (t % MCLK_DIV) >= MCLK_DIV / 2);
        check("sck", audio_sck, (t % SCK_DIV) >= SCK_DIV / 2);
        check("lrck", audio_lrck, b >= SLOT_W);
        check("sdin", audio_sdin, exp_sdin);
        check("s_ready", s_ready, m_rdy_ok && !m_full);
        check("frame_start", frame_start, m_fs);
        check("underrun", underrun, m_uf);
        if (t % SCK_DIV == SCK_DIV / 2) begin
            if (t / P == 1) cap1 = {cap1[30:0], audio_sdin};
            if (t / P == 2) cap2 = {cap2[30:0], audio_sdin};
            if (t / P == 2) begin
                sb = b % 16;
                check("dw12_sdin", b_sdin, (b < 16) ? exp12_l[15-sb] : exp12_r[15-sb]);
            end
        end
        if (underrun === 1'b1) uf_seen++;
    endtask

    task automatic step(input bit rst_v, input bit valid_v,
                        input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        bit acc;
        bit bnd;
        check_outputs();
        rst     = rst_v;
        s_valid = valid_v;
        s_left  = l;
        s_right = r;
        if (rst_v) begin
            t = 0; m_full = 0; m_rdy_ok = 0; m_fs = 0; m_uf = 0;
            m_cur = '0; m_prev = '0; m_last_l = '0; m_last_r = '0;
        end else begin
            acc  = valid_v && m_rdy_ok && !m_full;
            bnd  = (t % P) == P - 1;
            m_fs = bnd;
            m_uf = bnd && !m_full;
            if (bnd) begin
                m_prev = m_cur;
                if (m_full) begin
                    m_cur    = frame_of(m_hold_l, m_hold_r);
                    m_last_l = m_hold_l;
                    m_last_r = m_hold_r;
                end else begin
`ifdef SPK_UNDERRUN_REPEAT_EN
                    m_cur = frame_of(m_last_l, m_last_r);
`else
                    m_cur = '0;
`endif
                end
                m_full = acc;
            end else begin
                m_full = m_full || acc;
            end
            if (acc) begin
                m_hold_l = l;
                m_hold_r = r;
            end
            t++;
            m_rdy_ok = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] exp_rep;
        rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        t = 0; m_full = 0; m_rdy_ok = 0; m_fs = 0; m_uf = 0;
        m_cur = '0; m_prev = '0; m_last_l = '0; m_last_r = '0;
        m_hold_l = '0; m_hold_r = '0; cap1 = '0; cap2 = '0; uf_seen = 0;
        @(posedge clk);
        @(negedge clk);

        // Directed: reset, one pushed pair, then starve the transmitter.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 16'hA5C3, 16'h0F01);
        while (t < 3 * P + 10) step(1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom));
        check("frame1_bits", cap1, 32'hA5C30F01);
`ifdef SPK_UNDERRUN_REPEAT_EN
        exp_rep = 32'hA5C30F01;
`else
        exp_rep = 32'h0;
`endif
        check("underrun_frame_bits", cap2, exp_rep);
        check("underrun_count", uf_seen, 2);

        // Random handshake traffic.
        for (int i = 0; i < 6 * P; i++) begin
            step(1'b0, $urandom_range(0, 3) == 0, DATA_W'($urandom), DATA_W'($urandom));
        end

        // Reset in the middle of a frame while a sample is held.
        n = 0;
        while (!(m_full && t >= P && (t % P) == 20 * SCK_DIV + 5) && n < 3 * P) begin
            step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom));
            n++;
        end
        check("midrst_reached", n < 3 * P, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3 * P; i++) begin
            step(1'b0, $urandom_range(0, 2) == 0, DATA_W'($urandom), DATA_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_tx_param.md
I2S_TX_PARAM -- requirements
Module: i2s_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample bits per channel (1..SLOT_W).
REQ-002 The block SHALL have parameter SLOT_W, default 16, meaning sck periods per channel slot (frame = 2*SLOT_W bits).
REQ-003 The block SHALL have parameter SCK_DIV, default 16, meaning clk_100mhz cycles per audio_sck period (even, >=4).
REQ-004 The block SHALL have parameter MCLK_DIV, default 4, meaning clk_100mhz cycles per audio_mclk period (even, >=2).
REQ-005 The block SHALL have parameter I2S_DELAY, default 0, meaning 0 = left-justified and 1 = standard I2S one-sck data delay.
REQ-006 The block SHALL have port clk_100mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports s_left and s_right, input, DATA_W bits each: the stereo sample pair.
REQ-009 The block SHALL have ports s_valid (input, 1) and s_ready (output, 1): the sample handshake.
REQ-010 The block SHALL have ports audio_mclk, audio_lrck, audio_sck and audio_sdin, output, 1 bit each, all registered.
REQ-011 The block SHALL have ports frame_start and underrun, output, 1 bit each: single-cycle status pulses.

Function
REQ-012 The block SHALL divide clocks with a free-running mclk counter: audio_mclk low for MCLK_DIV/2 cycles, then high for MCLK_DIV/2 cycles.
REQ-013 The block SHALL run an sck counter c over 0..SCK_DIV-1, with audio_sck=0 for c<SCK_DIV/2 and 1 otherwise; a falling edge occurs at the c wrap.
REQ-014 The block SHALL advance bit counter b over 0..2*SLOT_W-1 at each c wrap; audio_lrck=0 for b<SLOT_W (left slot) and 1 otherwise.
REQ-015 The block SHALL hold a single-entry sample register, with s_ready = NOT hold_full and a sample accepted on s_valid AND s_ready.
REQ-016 The frame boundary SHALL be the cycle with c=SCK_DIV-1 and b=2*SLOT_W-1; on it the block asserts frame_start for one cycle and loads the 2*SLOT_W-bit shift register with {s_left, zeros, s_right, zeros}, MSB first, and clears hold_full.
REQ-017 If the hold register is empty at the boundary, the block SHALL pulse underrun and load per REQ-026; a sample accepted in that same cycle fills the hold register for the following frame.
REQ-018 The shift register SHALL shift once per sck falling edge; with I2S_DELAY=0, audio_sdin = current MSB, changing only on sck falling edges.
REQ-019 With I2S_DELAY=1, audio_sdin SHALL equal the REQ-018 stream delayed one sck period, so the previous frame's last bit appears during bit 0 of the next frame.
REQ-020 Latency SHALL be: a sample accepted before boundary N is transmitted in the frame starting at boundary N.
REQ-021 Slot bits at positions DATA_W..SLOT_W-1 SHALL transmit 0.

Reset
REQ-022 While rst=1, the block SHALL drive all outputs to 0 (including s_ready), counters to 0, shift register and delay flop to 0, and hold_full to 0.
REQ-023 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-024 The first frame after reset SHALL transmit all zeros with no underrun pulse.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard any held sample.

Configuration
REQ-026 With macro SPK_UNDERRUN_REPEAT_EN defined, an underrun boundary SHALL reload the last loaded sample pair; when undefined, it SHALL load zeros; underrun pulses in both cases.

Verification
REQ-027 With defaults, hold rst 3 cycles: all outputs 0 and s_ready=0 throughout; s_ready=1 on the cycle after release; audio_lrck period is 512 cycles and audio_mclk period is 4 cycles.
REQ-028 With defaults, push left=16'hA5C3 and right=16'h0F01 before boundary 1: audio_sdin sampled at sck rising edges in frame 2 reads 1010010111000011 (lrck=0), then 0000111100000001 (lrck=1).
REQ-029 With defaults and no push after REQ-028: underrun=1 for one cycle at the next boundary; the next frame sends A5C3/0F01 with SPK_UNDERRUN_REPEAT_EN defined and all zeros without it.
REQ-030 With DATA_W=12, SLOT_W=16, I2S_DELAY=1, send left=12'hABC and right=12'h123: bit 0 of the left slot is 0, bits 1..12 are 101010111100, and the remainder are 0; the right slot follows the same pattern.
REQ-031 With defaults, hold s_valid with two samples queued: the second waits with s_ready=0 until the boundary; s_ready=1 on the cycle after the load; the second pair is transmitted one frame after the first.
REQ-032 Assert rst at b=20 mid-frame with a held sample: outputs are 0 immediately; after release the held sample is never transmitted and the first frame is all zeros.
